// File: rtl/word_tx_bridge.sv
// word_tx_bridge: word FIFO feeding a byte serializer and UART transmitter
module word_tx_bridge #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int CLKS_PER_BIT = 326,
  parameter int MSB_FIRST = 1,
  parameter int STOP_BITS = 1
) (
  input logic CLK,
  input logic RESET,
  input logic [DATA_W-1:0] DATA_IN,
  input logic WR,
  input logic CLR_OVF,
  output logic TX,
  output logic FULL,
  output logic EMPTY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic BUSY,
  output logic OVERFLOW
);
  localparam int BYTES = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int FRAME = 9 + STOP_BITS;
  localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  state_t st, nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt_n;
  logic push, pop, start, done, more, active, tick_end;
  logic [DATA_W-1:0] sr;
  logic [IW-1:0] idx;
  logic [7:0] cur_byte, sh;
  logic [CW-1:0] cnt;
  logic [3:0] bitn;
  assign push = WR && !FULL;
  assign cnt_n = COUNT + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign more = int'(idx) < BYTES - 1;
  assign cur_byte = MSB_FIRST != 0 ? sr[DATA_W-1 -: 8] : sr[7:0];
  assign tick_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign done = active && tick_end && bitn == 4'(FRAME - 1);
  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge CLK)
    if (push) mem[wptr] <= DATA_IN;
  // FIFO pointers, registered flags and sticky overflow (set beats clear)
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
      COUNT <= '0;
      FULL <= 1'b0;
      EMPTY <= 1'b1;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      COUNT <= cnt_n;
      FULL <= cnt_n == (AW+1)'(DEPTH);
      EMPTY <= cnt_n == '0;
      OVERFLOW <= (WR && FULL) || (OVERFLOW && !CLR_OVF);
    end
  // Serializer next state: a new byte starts on the very edge the previous stop bit ends
  always_comb begin
    nx = st;
    start = 1'b0;
    pop = 1'b0;
    case (st)
      IDLE: begin
        pop = !EMPTY;
        nx = EMPTY ? IDLE : LOAD;
      end
      LOAD: begin
        start = 1'b1;
        nx = SEND;
      end
      SEND: nx = WAIT;
      WAIT: begin
        start = done && more;
        nx = done ? (more ? SEND : IDLE) : WAIT;
      end
      default: nx = IDLE;
    endcase
  end
  // Serializer state, word shift register, byte index and BUSY tracking
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      st <= IDLE;
      sr <= '0;
      idx <= '0;
      BUSY <= 1'b0;
    end else begin
      st <= nx;
      if (pop) begin
        sr <= mem[rptr];
        idx <= '0;
      end else if (start) begin
        sr <= MSB_FIRST != 0 ? sr << 8 : sr >> 8;
        if (st == WAIT) idx <= idx + 1'b1;
      end
      BUSY <= pop ? 1'b1 : (st == WAIT && done && !more) ? !EMPTY : BUSY;
    end
  // UART: start bit on load, then data LSB first; ones shifted in form the stop bits
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      TX <= 1'b1;
      active <= 1'b0;
      sh <= '0;
      cnt <= '0;
      bitn <= '0;
    end else if (start) begin
      TX <= 1'b0;
      active <= 1'b1;
      sh <= cur_byte;
      cnt <= '0;
      bitn <= '0;
    end else if (active) begin
      if (tick_end) begin
        cnt <= '0;
        bitn <= bitn + 1'b1;
        TX <= sh[0];
        sh <= {1'b1, sh[7:1]};
        active <= !done;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_word_tx_bridge.sv
// tb_word_tx_bridge: scoreboard bench decoding UART frames from three bridge configurations
module tb_word_tx_bridge;
  localparam int CPB = 4;
  logic clk;
  logic [2:0] rst, wr, clr, txv, full, empty, busyv, ovf, abort;
  logic [15:0] d0, d1;
  logic [31:0] d2;
  logic [3:0] cnt0, cnt1, cnt2;
  logic [7:0] q0[$], q1[$], q2[$];
  logic [7:0] b0, b1, b2;
  int n_chk = 0, n_err = 0;

  word_tx_bridge #(.DATA_W(16), .DEPTH(8), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .STOP_BITS(1)) dut0 (
    .CLK(clk), .RESET(rst[0]), .DATA_IN(d0), .WR(wr[0]), .CLR_OVF(clr[0]), .TX(txv[0]),
    .FULL(full[0]), .EMPTY(empty[0]), .COUNT(cnt0), .BUSY(busyv[0]), .OVERFLOW(ovf[0]));
  word_tx_bridge #(.DATA_W(16), .DEPTH(8), .CLKS_PER_BIT(CPB), .MSB_FIRST(0), .STOP_BITS(1)) dut1 (
    .CLK(clk), .RESET(rst[1]), .DATA_IN(d1), .WR(wr[1]), .CLR_OVF(clr[1]), .TX(txv[1]),
    .FULL(full[1]), .EMPTY(empty[1]), .COUNT(cnt1), .BUSY(busyv[1]), .OVERFLOW(ovf[1]));
  word_tx_bridge #(.DATA_W(32), .DEPTH(8), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RESET(rst[2]), .DATA_IN(d2), .WR(wr[2]), .CLR_OVF(clr[2]), .TX(txv[2]),
    .FULL(full[2]), .EMPTY(empty[2]), .COUNT(cnt2), .BUSY(busyv[2]), .OVERFLOW(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int d);
    return d == 0 ? q0.size() : d == 1 ? q1.size() : q2.size();
  endfunction

  task automatic score(input int d, input logic [7:0] b);
    logic [7:0] e;
    check($sformatf("rx%0d_pending", d), {31'b0, qsize(d) > 0}, 1);
    if (qsize(d) > 0) begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("rx%0d_byte", d), {24'b0, b}, {24'b0, e});
    end
  endtask

  task automatic rx_byte(input int d, input int ns, output logic [7:0] b);
    @(negedge clk);
    while (txv[d] !== 1'b0) @(negedge clk);
    @(negedge clk);
    if (!abort[d]) check($sformatf("rx%0d_start", d), {31'b0, txv[d]}, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = txv[d];
    end
    for (int i = 0; i < ns; i++) begin
      repeat (CPB) @(negedge clk);
      if (!abort[d]) check($sformatf("rx%0d_stop", d), {31'b0, txv[d]}, 1);
    end
  endtask

  initial forever begin
    rx_byte(0, 1, b0);
    if (!abort[0]) score(0, b0);
  end
  initial forever begin
    rx_byte(1, 1, b1);
    if (!abort[1]) score(1, b1);
  end
  initial forever begin
    rx_byte(2, 2, b2);
    if (!abort[2]) score(2, b2);
  end

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while ((qsize(d) != 0 || busyv[d]) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("idle%0d", d), {31'b0, qsize(d) == 0 && !busyv[d]}, 1);
  endtask

  initial begin
    int lows;
    rst = 3'b111;
    wr = '0;
    clr = '0;
    abort = '0;
    d0 = '0;
    d1 = '0;
    d2 = '0;
    repeat (3) tick();
    check("rst_tx", {29'b0, txv}, 32'h7);
    check("rst_full", {31'b0, full[0]}, 0);
    check("rst_empty", {29'b0, empty}, 32'h7);
    check("rst_count", {28'b0, cnt0}, 0);
    check("rst_busy", {29'b0, busyv}, 0);
    check("rst_ovf", {31'b0, ovf[0]}, 0);
    rst = '0;
    // 0xA55A, MSB first: exact start edge, zero gap between bytes, 80 clocks
    d0 = 16'hA55A;
    wr[0] = 1'b1;
    q0.push_back(8'hA5);
    q0.push_back(8'h5A);
    tick();
    wr[0] = 1'b0;
    check("k_tx", {31'b0, txv[0]}, 1);
    check("k_empty", {31'b0, empty[0]}, 0);
    check("k_count", {28'b0, cnt0}, 1);
    check("k_busy", {31'b0, busyv[0]}, 0);
    tick();
    check("k1_tx", {31'b0, txv[0]}, 1);
    check("k1_busy", {31'b0, busyv[0]}, 1);
    check("k1_empty", {31'b0, empty[0]}, 1);
    tick();
    check("k2_start", {31'b0, txv[0]}, 0);
    repeat (39) tick();
    check("k41_stop", {31'b0, txv[0]}, 1);
    tick();
    check("k42_start2", {31'b0, txv[0]}, 0);
    repeat (39) tick();
    check("k81_stop", {31'b0, txv[0]}, 1);
    check("k81_busy", {31'b0, busyv[0]}, 1);
    tick();
    check("k82_busy", {31'b0, busyv[0]}, 0);
    check("k82_tx", {31'b0, txv[0]}, 1);
    wait_idle(0, 200);
    // LSB-first byte order
    d1 = 16'h1234;
    wr[1] = 1'b1;
    q1.push_back(8'h34);
    q1.push_back(8'h12);
    tick();
    wr[1] = 1'b0;
    wait_idle(1, 300);
    // 32-bit word, two stop bits: 44 clocks per byte
    d2 = 32'hDEADBEEF;
    wr[2] = 1'b1;
    q2.push_back(8'hDE);
    q2.push_back(8'hAD);
    q2.push_back(8'hBE);
    q2.push_back(8'hEF);
    tick();
    wr[2] = 1'b0;
    tick();
    tick();
    check("w32_start", {31'b0, txv[2]}, 0);
    repeat (43) tick();
    check("w32_stop2", {31'b0, txv[2]}, 1);
    tick();
    check("w32_next", {31'b0, txv[2]}, 0);
    wait_idle(2, 400);
    // ten back-to-back writes into an eight-deep FIFO, clear racing the overflow set
    for (int i = 0; i < 10; i++) begin
      d0 = {8'(8'h30 + i), 8'(8'hC0 + i)};
      wr[0] = 1'b1;
      clr[0] = (i == 9);
      if (i < 9) begin
        q0.push_back(8'(8'h30 + i));
        q0.push_back(8'(8'hC0 + i));
      end
      tick();
      if (i == 7) check("e7_full", {31'b0, full[0]}, 0);
      if (i == 8) begin
        check("e8_full", {31'b0, full[0]}, 1);
        check("e8_count", {28'b0, cnt0}, 8);
        check("e8_ovf", {31'b0, ovf[0]}, 0);
      end
    end
    check("e9_ovf", {31'b0, ovf[0]}, 1);
    check("e9_count", {28'b0, cnt0}, 8);
    wr[0] = 1'b0;
    tick();
    clr[0] = 1'b0;
    check("e10_ovf_clr", {31'b0, ovf[0]}, 0);
    repeat (73) tick();
    check("e83_gap", {31'b0, txv[0]}, 1);
    check("e83_busy", {31'b0, busyv[0]}, 1);
    tick();
    check("e84_start", {31'b0, txv[0]}, 0);
    wait_idle(0, 1500);
    // reset during the second byte: frame aborted, FIFO discarded
    d0 = 16'h1357;
    wr[0] = 1'b1;
    q0.push_back(8'h13);
    tick();
    d0 = 16'h2468;
    tick();
    wr[0] = 1'b0;
    repeat (52) tick();
    abort[0] = 1'b1;
    #2 rst[0] = 1'b1;
    #1;
    check("mid_rst_tx", {31'b0, txv[0]}, 1);
    check("mid_rst_empty", {31'b0, empty[0]}, 1);
    check("mid_rst_count", {28'b0, cnt0}, 0);
    check("mid_rst_busy", {31'b0, busyv[0]}, 0);
    tick();
    rst[0] = 1'b0;
    lows = 0;
    repeat (200) begin
      tick();
      if (txv[0] !== 1'b1) lows++;
    end
    check("post_rst_quiet", lows, 0);
    check("post_rst_empty", {31'b0, empty[0]}, 1);
    check("post_rst_q0", qsize(0), 0);
    abort[0] = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
